lzc_norm_pipe: RTL

//  Parametrised, pipelined zero counter and normaliser for the FPU datapath.
//  - Counts leading zeros (mode 0) or trailing zeros (mode 1) of a WIDTH-bit operand.
//  - Returns the operand shifted by that count: left in mode 0, right in mode 1.
//  - Sits between the mantissa add/sub stage and the exponent-adjust/rounding stage.
//  - valid/ready handshake on both sides.

---
 rtl/fpu_pkg.sv | 14 +
 rtl/lzc_tree.sv | 49 ++++
 rtl/lzc_norm_pipe.sv | 118 +++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared types and helpers for the FPU zero-count / normalise datapath.
package fpu_pkg;

    typedef enum logic {
        LZC_LEAD  = 1'b0,
        LZC_TRAIL = 1'b1
    } lzc_mode_e;

    // Count width able to represent the value `width` itself (all-zero operand).
    function automatic int cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/lzc_tree.sv
// Combinational leading-zero counter built as a recursive tree of 4-bit leaves.
module lzc_tree
    import fpu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = cnt_w(WIDTH)
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [CNT_W-1:0] count_o,
    output logic             zero_o
);

    if (WIDTH == 4) begin : g_leaf
        always_comb begin
            zero_o = (data_i == 4'b0000);
            casez (data_i)
                4'b1???: count_o = CNT_W'(0);
                4'b01??: count_o = CNT_W'(1);
                4'b001?: count_o = CNT_W'(2);
                4'b0001: count_o = CNT_W'(3);
                default: count_o = CNT_W'(4);
            endcase
        end
    end else begin : g_node
        localparam int HW = WIDTH / 2;
        localparam int HC = cnt_w(HW);

        logic [HC-1:0] cnt_hi, cnt_lo;
        logic          zero_hi, zero_lo;

        lzc_tree #(.WIDTH(HW)) u_hi (
            .data_i  (data_i[WIDTH-1:HW]),
            .count_o (cnt_hi),
            .zero_o  (zero_hi)
        );

        lzc_tree #(.WIDTH(HW)) u_lo (
            .data_i  (data_i[HW-1:0]),
            .count_o (cnt_lo),
            .zero_o  (zero_lo)
        );

        // A child's count MSB is set only when that half is all zero.
        assign zero_o  = cnt_hi[HC-1] & cnt_lo[HC-1];
        assign count_o = {zero_hi & zero_lo, zero_hi & ~zero_lo,
                          zero_hi ? cnt_lo[HC-2:0] : cnt_hi[HC-2:0]};
    end

endmodule

// File: rtl/lzc_norm_pipe.sv
// Two-stage leading/trailing zero counter and normaliser with valid/ready on both sides.
module lzc_norm_pipe
    import fpu_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int TAG_W = 4,
    localparam int CNT_W = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             out_zero,
    output logic [WIDTH-1:0] out_norm,
    output logic [TAG_W-1:0] out_tag
);

    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_data_q;
    lzc_mode_e        s1_mode_q;
    logic [TAG_W-1:0] s1_tag_q;
    logic [CNT_W-1:0] s1_cnt_q;
    logic             s1_zero_q;

    logic             s2_valid_q;
    logic [WIDTH-1:0] s2_norm_q;
    logic [CNT_W-1:0] s2_cnt_q;
    logic             s2_zero_q;
    logic [TAG_W-1:0] s2_tag_q;

    logic             s2_adv;
    logic             in_fire;
    logic [WIDTH-1:0] tree_in;
    logic [CNT_W-1:0] cnt_d;
    logic             zero_d;
    logic [WIDTH-1:0] norm_d;
    logic [CNT_W-2:0] shamt;

    assign s2_adv   = ~s2_valid_q | out_ready;
    assign in_ready = ~s1_valid_q | s2_adv;
    assign in_fire  = in_valid & in_ready;

    // Trailing zeros are the leading zeros of the bit-reversed operand.
    always_comb begin
        tree_in = in_data;
        if (lzc_mode_e'(in_mode) == LZC_TRAIL) begin
            for (int i = 0; i < WIDTH; i++) tree_in[i] = in_data[WIDTH-1-i];
        end
    end

    lzc_tree #(.WIDTH(WIDTH)) u_lzc (
        .data_i  (tree_in),
        .count_o (cnt_d),
        .zero_o  (zero_d)
    );

    assign shamt = s1_cnt_q[CNT_W-2:0];

    always_comb begin
        norm_d = '0;
        if (!s1_zero_q) begin
            norm_d = (s1_mode_q == LZC_TRAIL) ? (s1_data_q >> shamt) : (s1_data_q << shamt);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_mode_q  <= LZC_LEAD;
            s1_tag_q   <= '0;
            s1_cnt_q   <= '0;
            s1_zero_q  <= 1'b0;
        end else begin
            if (in_fire) begin
                s1_valid_q <= 1'b1;
                s1_data_q  <= in_data;
                s1_mode_q  <= lzc_mode_e'(in_mode);
                s1_tag_q   <= in_tag;
                s1_cnt_q   <= cnt_d;
                s1_zero_q  <= zero_d;
            end else if (s2_adv) begin
                s1_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_norm_q  <= '0;
            s2_cnt_q   <= '0;
            s2_zero_q  <= 1'b0;
            s2_tag_q   <= '0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_norm_q <= norm_d;
                s2_cnt_q  <= s1_cnt_q;
                s2_zero_q <= s1_zero_q;
                s2_tag_q  <= s1_tag_q;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_count = s2_cnt_q;
    assign out_zero  = s2_zero_q;
    assign out_norm  = s2_norm_q;
    assign out_tag   = s2_tag_q;

endmodule
